// File: rtl/axis_spike_dispatcher_pkg.sv
// Shared types and packet field helpers for the AXI-Stream spike dispatcher.
// Contents:
//   opcode_t : 2-bit command opcodes carried in the top bits of every packet
//   state_t  : dispatcher sequencing states
//   OP_WIDTH : opcode field width
//   idx_width(), op_lsb(), idx_lsb(), charge_lsb() : field position helpers
package axis_spike_dispatcher_pkg;

  localparam int OP_WIDTH = 2;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RUN = 2'b01,
    OP_AS  = 2'b10,
    OP_CLR = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    WAIT,
    EMIT
  } state_t;

  // Index field is never narrower than one bit, even for a single input.
  function automatic int idx_width(input int num_inp);
    return (num_inp > 1) ? $clog2(num_inp) : 1;
  endfunction

  function automatic int op_lsb(input int pkt_w);
    return pkt_w - OP_WIDTH;
  endfunction

  function automatic int idx_lsb(input int pkt_w, input int idx_w);
    return pkt_w - OP_WIDTH - idx_w;
  endfunction

  function automatic int charge_lsb(input int pkt_w, input int idx_w,
                                    input int charge_w);
    return pkt_w - OP_WIDTH - idx_w - charge_w;
  endfunction

endpackage

// File: rtl/axis_spike_dispatcher.sv
// AXI-Stream front end for the spiking-network processor.
// Decodes host command packets (NOP, RUN, AS, CLR) into one-cycle network
// strobes, sequences multi-timestep RUN commands and returns one output-fire
// packet per timestep on the AXIS master.
//
// Ports:
//   clk, arst                    clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tready   command stream (accepted only while idle)
//   m_axis_tdata/tvalid/tready   fire packets, fire bits in [NUM_OUT-1:0]
//   net_inp_valid/idx/charge     spike-apply strobe with target and charge
//   net_clear                    network clear strobe
//   net_run                      timestep strobe
//   net_out_valid, net_out       timestep completion and fire vector
//   err_idx, err_cnt             (AXIS_SPIKE_DISPATCHER_ERR_EN only) sticky
//                                out-of-range AS flag and saturating count
//
// Optional feature macro: AXIS_SPIKE_DISPATCHER_ERR_EN
module axis_spike_dispatcher
  import axis_spike_dispatcher_pkg::*;
#(
  parameter int PKT_WIDTH    = 8,
  parameter int NUM_INP      = 2,
  parameter int NUM_OUT      = 2,
  parameter int CHARGE_WIDTH = 4,
  parameter int RUN_WIDTH    = 6,
  localparam int IDX_W       = idx_width(NUM_INP)
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [PKT_WIDTH-1:0]    s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [PKT_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    net_inp_valid,
  output logic [IDX_W-1:0]        net_inp_idx,
  output logic [CHARGE_WIDTH-1:0] net_inp_charge,
  output logic                    net_clear,
  output logic                    net_run,
  input  logic                    net_out_valid,
  input  logic [NUM_OUT-1:0]      net_out
`ifdef AXIS_SPIKE_DISPATCHER_ERR_EN
  ,
  output logic                    err_idx,
  output logic [15:0]             err_cnt
`endif
);

  localparam int OP_LSB     = op_lsb(PKT_WIDTH);
  localparam int IDX_LSB    = idx_lsb(PKT_WIDTH, IDX_W);
  localparam int CHARGE_LSB = charge_lsb(PKT_WIDTH, IDX_W, CHARGE_WIDTH);

  if (OP_WIDTH + IDX_W + CHARGE_WIDTH > PKT_WIDTH) begin : g_bad_as_layout
    $error("AS fields (op+idx+charge) do not fit in PKT_WIDTH");
  end
  if (RUN_WIDTH > PKT_WIDTH - OP_WIDTH) begin : g_bad_run_width
    $error("RUN_WIDTH exceeds PKT_WIDTH-2");
  end
  if (NUM_OUT > PKT_WIDTH) begin : g_bad_num_out
    $error("NUM_OUT exceeds PKT_WIDTH");
  end
  if (NUM_INP < 1 || NUM_OUT < 1 || CHARGE_WIDTH < 1 || RUN_WIDTH < 1) begin : g_bad_sizes
    $error("NUM_INP, NUM_OUT, CHARGE_WIDTH and RUN_WIDTH must be at least 1");
  end

  state_t                  state;
  state_t                  state_next;
  logic [RUN_WIDTH-1:0]    count;

  opcode_t                 pkt_op;
  logic [IDX_W-1:0]        pkt_idx;
  logic [CHARGE_WIDTH-1:0] pkt_charge;
  logic [RUN_WIDTH-1:0]    pkt_count;
  logic                    accept;
  logic                    idx_ok;
  logic                    as_good;
  logic                    as_bad;
  logic                    clr_hit;
  logic                    run_hit;
  logic                    emit_done;
  logic [PKT_WIDTH-1:0]    fire_ext;

  // Not every packet bit is decoded (pad bits below the AS/RUN fields).
  logic                    unused_pkt_bits;
  assign unused_pkt_bits = ^s_axis_tdata;

  assign pkt_op     = opcode_t'(s_axis_tdata[OP_LSB +: OP_WIDTH]);
  assign pkt_idx    = s_axis_tdata[IDX_LSB +: IDX_W];
  assign pkt_charge = s_axis_tdata[CHARGE_LSB +: CHARGE_WIDTH];
  assign pkt_count  = s_axis_tdata[RUN_WIDTH-1:0];

  assign s_axis_tready = (state == IDLE) && !arst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign idx_ok        = int'(pkt_idx) < NUM_INP;
  assign as_good       = accept && (pkt_op == OP_AS) && idx_ok;
  assign as_bad        = accept && (pkt_op == OP_AS) && !idx_ok;
  assign clr_hit       = accept && (pkt_op == OP_CLR);
  assign run_hit       = accept && (pkt_op == OP_RUN) && (pkt_count != '0);
  assign emit_done     = (state == EMIT) && m_axis_tready;

  always_comb begin
    fire_ext                = '0;
    fire_ext[NUM_OUT-1:0]   = net_out;
  end

  always_comb begin
    state_next    = state;
    net_run       = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state)
      IDLE: begin
        if (run_hit) state_next = STEP;
      end
      STEP: begin
        net_run    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (net_out_valid) state_next = EMIT;
      end
      EMIT: begin
        m_axis_tvalid = 1'b1;
        // Leaving on the last step: the counter is about to reach zero.
        if (m_axis_tready) state_next = (count == RUN_WIDTH'(1)) ? IDLE : STEP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state          <= IDLE;
      count          <= '0;
      m_axis_tdata   <= '0;
      net_inp_valid  <= 1'b0;
      net_inp_idx    <= '0;
      net_inp_charge <= '0;
      net_clear      <= 1'b0;
    end else begin
      state         <= state_next;
      net_inp_valid <= as_good;
      net_clear     <= clr_hit;
      if (as_good) begin
        net_inp_idx    <= pkt_idx;
        net_inp_charge <= pkt_charge;
      end
      if (run_hit) begin
        count <= pkt_count;
      end else if (emit_done) begin
        count <= count - RUN_WIDTH'(1);
      end
      if ((state == WAIT) && net_out_valid) begin
        m_axis_tdata <= fire_ext;
      end
    end
  end

`ifdef AXIS_SPIKE_DISPATCHER_ERR_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_idx <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (as_bad) begin
        err_idx <= 1'b1;
      end else if (clr_hit) begin
        err_idx <= 1'b0;
      end
      if (as_bad && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_as_bad;
  assign unused_as_bad = as_bad;
`endif

endmodule

// File: tb/tb_axis_spike_dispatcher.sv
// Scoreboard bench for axis_spike_dispatcher. Commands are issued by a
// driver that also predicts strobes/packets; a network stub answers each
// timestep; an independent monitor compares everything the DUT presents.
module tb_axis_spike_dispatcher;

  localparam int PKT_WIDTH    = 8;
  localparam int NUM_INP      = 3;
  localparam int NUM_OUT      = 2;
  localparam int CHARGE_WIDTH = 4;
  localparam int RUN_WIDTH    = 6;
  localparam int IDX_W        = 2;

  logic                    clk;
  logic                    arst;
  logic [PKT_WIDTH-1:0]    s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic [PKT_WIDTH-1:0]    m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    net_inp_valid;
  logic [IDX_W-1:0]        net_inp_idx;
  logic [CHARGE_WIDTH-1:0] net_inp_charge;
  logic                    net_clear;
  logic                    net_run;
  logic                    net_out_valid;
  logic [NUM_OUT-1:0]      net_out;
`ifdef AXIS_SPIKE_DISPATCHER_ERR_EN
  logic                    err_idx;
  logic [15:0]             err_cnt;
`endif

  axis_spike_dispatcher #(
    .PKT_WIDTH   (PKT_WIDTH),
    .NUM_INP     (NUM_INP),
    .NUM_OUT     (NUM_OUT),
    .CHARGE_WIDTH(CHARGE_WIDTH),
    .RUN_WIDTH   (RUN_WIDTH)
  ) dut (
    .clk           (clk),
    .arst          (arst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .net_inp_valid (net_inp_valid),
    .net_inp_idx   (net_inp_idx),
    .net_inp_charge(net_inp_charge),
    .net_clear     (net_clear),
    .net_run       (net_run),
    .net_out_valid (net_out_valid),
    .net_out       (net_out)
`ifdef AXIS_SPIKE_DISPATCHER_ERR_EN
    ,
    .err_idx       (err_idx),
    .err_cnt       (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit clr;
    int idx;
    int charge;
  } strobe_t;

  strobe_t              exp_strobe[$];
  logic [PKT_WIDTH-1:0] exp_pkt[$];

  int total = 0;
  int bad   = 0;
  int run_left       = 0;
  bit run_pending    = 0;
  int steps_expected = 0;
  int steps_seen     = 0;
  bit net_hold       = 0;
  bit force_low      = 0;
  bit exp_err_idx    = 0;
  int exp_err_cnt    = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model of one accepted command, applied just after the
  // handshake edge; strobes are due in the cycle that edge starts.
  task automatic apply_model(input logic [7:0] pkt);
    logic [1:0] op;
    strobe_t    s;
    op = pkt[7:6];
    case (op)
      2'b01: begin
        if (pkt[5:0] != 0) begin
          run_left       = int'(pkt[5:0]);
          steps_expected += int'(pkt[5:0]);
        end
      end
      2'b10: begin
        if (int'(pkt[5:4]) < NUM_INP) begin
          s.cyc = cyc; s.clr = 0; s.idx = int'(pkt[5:4]); s.charge = int'(pkt[3:0]);
          exp_strobe.push_back(s);
        end else begin
          exp_err_idx = 1;
          if (exp_err_cnt < 65535) exp_err_cnt++;
        end
      end
      2'b11: begin
        s.cyc = cyc; s.clr = 1; s.idx = 0; s.charge = 0;
        exp_strobe.push_back(s);
        exp_err_idx = 0;
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [7:0] pkt);
    bit got;
    got = 0;
    s_axis_tdata  = pkt;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = s_axis_tready;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'($urandom);
    if (!got) fail_now("send_timeout");
    else apply_model(pkt);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (run_left == 0 && exp_pkt.size() == 0 && exp_strobe.size() == 0) break;
      @(posedge clk); #1;
    end
    if (i == 3000) fail_now(name);
  endtask

  // Output-side ready: random, or forced low to build back-pressure.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Network stub: answers each timestep 1..3 cycles later with a random
  // fire vector; otherwise occasionally raises stray completions that the
  // dispatcher must ignore.
  initial begin
    logic [PKT_WIDTH-1:0] e;
    logic [NUM_OUT-1:0]   v;
    bit aborted;
    net_out_valid = 1'b0;
    net_out       = '0;
    @(posedge clk); #1;
    forever begin
      if (!arst && net_run) begin
        aborted = 0;
        @(posedge clk); #1;
        for (int d = $urandom_range(0, 2); d > 0 && !aborted; d--) begin
          if (arst) aborted = 1;
          else begin @(posedge clk); #1; end
        end
        while (net_hold && !aborted) begin
          if (arst) aborted = 1;
          else begin @(posedge clk); #1; end
        end
        if (!aborted && !arst) begin
          v = NUM_OUT'($urandom);
          e = '0;
          e[NUM_OUT-1:0] = v;
          exp_pkt.push_back(e);
          net_out_valid = 1'b1;
          net_out       = v;
          @(posedge clk); #1;
          net_out_valid = 1'b0;
        end
      end else begin
        net_out_valid = !arst && ($urandom_range(0, 7) == 0);
        net_out       = NUM_OUT'($urandom);
        @(posedge clk); #1;
        net_out_valid = 1'b0;
      end
    end
  end

  // Monitor: samples on the falling edge, between active edges.
  initial begin
    bit                   stall_prev;
    logic [PKT_WIDTH-1:0] prev_data;
    strobe_t              s;
    stall_prev = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (arst) begin
        stall_prev = 0;
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_net_run", net_run, 0);
        check("rst_inp_valid", net_inp_valid, 0);
        check("rst_inp_fields", {net_inp_idx, net_inp_charge}, 0);
        check("rst_clear", net_clear, 0);
`ifdef AXIS_SPIKE_DISPATCHER_ERR_EN
        check("rst_err", {err_idx, err_cnt}, 0);
`endif
      end else begin
        check("s_tready", s_axis_tready, (run_left == 0));
        if (net_run) begin
          steps_seen++;
          check("net_run_allowed", (run_left > 0 && !run_pending), 1);
          check("net_run_overlap", (net_inp_valid || net_clear), 0);
          run_pending = 1;
        end
        if (stall_prev) begin
          check("hold_tvalid", m_axis_tvalid, 1);
          check("hold_tdata", m_axis_tdata, prev_data);
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_pkt.size() == 0) fail_now("pkt_unexpected");
          else check("pkt_data", m_axis_tdata, exp_pkt.pop_front());
          if (run_left > 0) run_left--;
          run_pending = 0;
        end
        if (net_inp_valid || net_clear) begin
          if (exp_strobe.size() == 0) fail_now("strobe_unexpected");
          else begin
            s = exp_strobe.pop_front();
            check("strobe_cycle", cyc, s.cyc);
            check("strobe_clear", net_clear, s.clr);
            check("strobe_inp", net_inp_valid, !s.clr);
            if (!s.clr) begin
              check("strobe_idx", net_inp_idx, s.idx);
              check("strobe_charge", net_inp_charge, s.charge);
            end
          end
        end else if (exp_strobe.size() > 0 && exp_strobe[0].cyc <= cyc) begin
          s = exp_strobe.pop_front();
          fail_now("strobe_missing");
        end
`ifdef AXIS_SPIKE_DISPATCHER_ERR_EN
        check("err_idx", err_idx, exp_err_idx);
        check("err_cnt", err_cnt, exp_err_cnt);
`endif
      end
    end
  end

  initial begin
    int s0;
    int i;
    logic [7:0] pkt;
    arst          = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Directed: clear, AS, back-to-back AS, out-of-range AS, RUN 3.
    send(8'hC0);
    send(8'b10_01_0101);
    send(8'b10_10_1111);
    send(8'b10_00_0001);
    send(8'b10_11_0110);
    send(8'h43);
    wait_idle("run3_timeout");

    // RUN 3 with the output held off during step 2.
    send(8'h43);
    for (i = 0; i < 200 && run_left != 2; i++) begin @(posedge clk); #1; end
    if (i == 200) fail_now("step2_timeout");
    force_low = 1;
    repeat (6) @(posedge clk); #1;
    force_low = 0;
    wait_idle("bp_timeout");

    // RUN 0 and NOP do nothing; CLR also drops the error flag.
    send(8'h40);
    send(8'h00);
    send(8'hC0);
    repeat (4) @(posedge clk); #1;

    // Abort a RUN 5 while waiting on the network.
    net_hold = 1;
    s0 = steps_seen;
    send(8'h45);
    for (i = 0; i < 50 && steps_seen == s0; i++) begin @(posedge clk); #1; end
    if (i == 50) fail_now("abort_step_timeout");
    repeat (2) @(posedge clk); #1;
    check("abort_no_pkt_pending", exp_pkt.size(), 0);
    arst = 1'b1;
    run_left       = 0;
    run_pending    = 0;
    steps_expected -= 4;
    exp_err_idx    = 0;
    exp_err_cnt    = 0;
    repeat (3) @(posedge clk); #1;
    net_hold = 0;
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (6) @(posedge clk); #1;
    send(8'h41);
    wait_idle("run1_timeout");

    // Randomised command stream.
    for (int n = 0; n < 150; n++) begin
      pkt = 8'($urandom);
      if (pkt[7:6] == 2'b01) begin
        if ($urandom_range(0, 15) == 0) pkt[5:0] = 6'($urandom_range(5, 12));
        else pkt[5:0] = 6'($urandom_range(0, 4));
      end
      send(pkt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle("final_timeout");
    repeat (5) @(posedge clk); #1;

    check("steps_total", steps_seen, steps_expected);
    check("pkt_queue_empty", exp_pkt.size(), 0);
    check("strobe_queue_empty", exp_strobe.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_spike_dispatcher.md
Name: axis_spike_dispatcher

Overview:
- Parametrised AXI-Stream front end for the spiking-network processor.
- Decodes opcode packets (NOP, RUN, AS, CLR) from the host stream into network-side strobes.
- Sequences multi-timestep RUN commands and emits one output-fire packet per timestep on an AXIS master.
- Generalises the fixed 8-bit processor interface to arbitrary packet width, input/output counts, charge width and run-count width, with per-step back-pressure.

Parameters:
- PKT_WIDTH, 8: width of s_axis/m_axis tdata.
- NUM_INP, 2: network input neurons; IDX_W = max(1, $clog2(NUM_INP)).
- NUM_OUT, 2: network output neurons; must be <= PKT_WIDTH.
- CHARGE_WIDTH, 4: AS charge field width; elaboration error if 2+IDX_W+CHARGE_WIDTH > PKT_WIDTH.
- RUN_WIDTH, 6: RUN count field width; elaboration error if RUN_WIDTH > PKT_WIDTH-2.

Ports:
- clk  in  1  single clock.
- arst  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  PKT_WIDTH  command packet.
- s_axis_tvalid  in  1  command valid.
- s_axis_tready  out  1  command ready.
- m_axis_tdata  out  PKT_WIDTH  output packet; fire bits in [NUM_OUT-1:0], upper bits 0.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- net_inp_valid  out  1  one-cycle spike-apply strobe.
- net_inp_idx  out  IDX_W  target input neuron.
- net_inp_charge  out  CHARGE_WIDTH  spike charge.
- net_clear  out  1  one-cycle network clear strobe.
- net_run  out  1  one-cycle timestep strobe.
- net_out_valid  in  1  network timestep complete.
- net_out  in  NUM_OUT  output fire vector, valid with net_out_valid.

Behaviour:
- Packet layout: op = tdata[PKT_WIDTH-1 -: 2]. Opcodes: 00 NOP, 01 RUN, 10 AS, 11 CLR.
  - AS: idx = next IDX_W bits below op, then charge = next CHARGE_WIDTH bits; remaining LSBs ignored.
  - RUN: count = tdata[RUN_WIDTH-1:0].
- Reset (arst high, any state): FSM to IDLE; counter 0; all registered outputs 0; s_axis_tready 0 while arst high.
- s_axis_tready = (state==IDLE) && !arst. Handshake = tvalid && tready at posedge clk.
- FSM states and transitions:
  - IDLE: accepts packets.
  - AS accepted at cycle T: net_inp_valid=1 at T+1 with registered idx/charge; stay IDLE. Back-to-back AS gives back-to-back strobes.
  - CLR accepted at T: net_clear=1 at T+1; stay IDLE.
  - NOP accepted: no effect.
  - RUN with count 0: no effect, stay IDLE.
  - RUN count N>0 accepted at T: load counter=N; go to STEP.
  - STEP: net_run=1 for exactly one cycle (T+1); next state WAIT.
  - WAIT: hold until net_out_valid=1. Capture net_out into m_axis_tdata (zero-extended); next state EMIT. net_out_valid outside WAIT is ignored.
  - EMIT: m_axis_tvalid=1; tdata stable until m_axis_tready. On handshake, counter decrements; if the new value is 0 go to IDLE, else go to STEP.
- Minimum step period is 3 cycles. RUN latency: net_run at T+1, m_axis_tvalid at earliest T+3.
- AS/CLR strobes issued at T+1 coincide with the first cycle of IDLE/STEP; no overlap with net_run is possible.
- Out-of-range AS idx (>= NUM_INP): packet consumed, no strobe.
- Counter is RUN_WIDTH bits; maximum run 2^RUN_WIDTH-1; no wrap.
- arst asserted mid-RUN: aborts immediately, pending output packet dropped, remaining steps discarded.

Optional Feature:
- Macro: AXIS_SPIKE_DISPATCHER_ERR_EN.
- Defined:
  - Adds output err_idx (1, sticky): set on out-of-range AS; cleared by arst or accepted CLR.
  - Adds output err_cnt (16, saturating): counts out-of-range AS; cleared by arst only.
- Undefined: ports absent; out-of-range AS silently dropped.

Decomposition:
- Package axis_spike_dispatcher_pkg holds:
  - opcode_t enum (OP_NOP, OP_RUN, OP_AS, OP_CLR) and state_t enum (IDLE, STEP, WAIT, EMIT).
  - OP_WIDTH=2 localparam.
  - Field-offset functions taking PKT_WIDTH/IDX_W.
- Single module; no sub-module is natural (FSM plus counter is compact).

Test Plan (default parameters; AS packet = op,idx,charge[4],pad):
- Reset: arst high for 3 cycles mid-stream -> all outputs 0, tready 0; first cycle after release tready=1, state IDLE.
- 8'hC0 (CLR) -> net_clear high exactly 1 cycle, 1 cycle after handshake. Then 8'b10101010 (AS idx1 ch5) -> net_inp_valid=1, idx=1, charge=4'd5, one cycle.
- 8'b01000011 (RUN 3), net model returns net_out_valid 1 cycle after net_run with net_out=2'b01,2'b10,2'b11 -> exactly 3 net_run pulses; m_axis_tdata 8'h01,8'h02,8'h03; tready low throughout, high after third handshake.
- RUN 3 with m_axis_tready held low 5 cycles on step 2 -> tdata/tvalid stable, no extra net_run; total still 3 packets.
- RUN 0 and NOP (8'h00) -> no net_run, no m_axis_tvalid, tready remains 1.
- arst during WAIT of RUN 5 -> no further net_run/m_axis_tvalid. Subsequent RUN 1 produces exactly 1 packet. With AXIS_SPIKE_DISPATCHER_ERR_EN: AS idx out-of-range (NUM_INP=3, idx 3) -> err_idx=1, err_cnt=1, no net_inp_valid.
